// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-port (fetch/data) to one-port memory arbiter, rev 1.0
// Option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data priority
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_imem_addr,
  input  logic [3:0]  i_imem_rmask,
  output logic [31:0] o_imem_rdata,
  output logic        o_imem_resp,
  input  logic [31:0] i_dmem_addr,
  input  logic [3:0]  i_dmem_rmask,
  input  logic [3:0]  i_dmem_wmask,
  input  logic [31:0] i_dmem_wdata,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_resp,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_rmask,
  output logic [3:0]  o_mem_wmask,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_resp,
  output logic [1:0]  o_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_ipend;
  logic [31:0] r_iaddr;
  logic [3:0]  r_irmask;
  logic        r_dpend;
  logic [31:0] r_daddr;
  logic [3:0]  r_drmask;
  logic [3:0]  r_dwmask;
  logic [31:0] r_dwdata;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_rmask;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_err;
  logic [31:0] r_cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        r_last_i;
`endif

  logic        w_ireq, w_dreq;
  logic        w_i_insvc, w_d_insvc;
  logic        w_icap, w_dcap, w_idrop, w_ddrop;
  logic        w_iavail, w_davail;
  logic        w_free, w_pick_d, w_gnt_i, w_gnt_d;
  logic [31:0] w_i_addr, w_d_addr, w_d_wdata;
  logic [3:0]  w_i_rmask, w_d_rmask, w_d_wmask;

  always_comb begin
    w_ireq    = |i_imem_rmask;
    w_dreq    = |(i_dmem_rmask | i_dmem_wmask);
    // A port whose response arrives this cycle is no longer in service.
    w_i_insvc = (r_state == S_BUSY_I) && !i_mem_resp;
    w_d_insvc = (r_state == S_BUSY_D) && !i_mem_resp;
    w_icap    = w_ireq && !r_ipend && !w_i_insvc;
    w_dcap    = w_dreq && !r_dpend && !w_d_insvc;
    w_idrop   = w_ireq && !w_icap;
    w_ddrop   = w_dreq && !w_dcap;
    w_iavail  = r_ipend || w_icap;
    w_davail  = r_dpend || w_dcap;
    w_free    = (r_state == S_IDLE) || i_mem_resp;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_pick_d  = w_davail && (!w_iavail || r_last_i);
`else
    w_pick_d  = w_davail;
`endif
    w_gnt_d   = w_free && w_pick_d;
    w_gnt_i   = w_free && w_iavail && !w_pick_d;
    // Incoming pulses bypass the empty slot so a grant costs no extra cycle.
    w_i_addr  = r_ipend ? r_iaddr  : i_imem_addr;
    w_i_rmask = r_ipend ? r_irmask : i_imem_rmask;
    w_d_addr  = r_dpend ? r_daddr  : i_dmem_addr;
    w_d_rmask = r_dpend ? r_drmask : i_dmem_rmask;
    w_d_wmask = r_dpend ? r_dwmask : i_dmem_wmask;
    w_d_wdata = r_dpend ? r_dwdata : i_dmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ipend     <= 1'b0;
      r_iaddr     <= '0;
      r_irmask    <= '0;
      r_dpend     <= 1'b0;
      r_daddr     <= '0;
      r_drmask    <= '0;
      r_dwmask    <= '0;
      r_dwdata    <= '0;
      r_mem_addr  <= '0;
      r_mem_rmask <= '0;
      r_mem_wmask <= '0;
      r_mem_wdata <= '0;
      r_err       <= '0;
      r_cnt       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_i    <= 1'b0;
`endif
    end else begin
      if (w_icap) begin
        r_iaddr  <= i_imem_addr;
        r_irmask <= i_imem_rmask;
      end
      if (w_dcap) begin
        r_daddr  <= i_dmem_addr;
        r_drmask <= i_dmem_rmask;
        r_dwmask <= i_dmem_wmask;
        r_dwdata <= i_dmem_wdata;
      end
      r_ipend <= w_iavail && !w_gnt_i;
      r_dpend <= w_davail && !w_gnt_d;
      if (w_idrop || w_ddrop)
        r_err[0] <= 1'b1;

      r_mem_rmask <= '0;
      r_mem_wmask <= '0;
      if (w_gnt_d) begin
        r_state     <= S_BUSY_D;
        r_mem_addr  <= w_d_addr;
        r_mem_rmask <= w_d_rmask;
        r_mem_wmask <= w_d_wmask;
        r_mem_wdata <= w_d_wdata;
        r_cnt       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        r_last_i    <= 1'b0;
`endif
      end else if (w_gnt_i) begin
        r_state     <= S_BUSY_I;
        r_mem_addr  <= w_i_addr;
        r_mem_rmask <= w_i_rmask;
        r_cnt       <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        r_last_i    <= 1'b1;
`endif
      end else if (r_state != S_IDLE && i_mem_resp) begin
        r_state <= S_IDLE;
      end else if (r_state != S_IDLE) begin
        if (r_cnt < TIMEOUT)
          r_cnt <= r_cnt + 32'd1;
        if (TIMEOUT != 0 && r_cnt == TIMEOUT - 1)
          r_err[1] <= 1'b1;
      end
    end
  end

  assign o_imem_rdata = i_mem_rdata;
  assign o_dmem_rdata = i_mem_rdata;
  assign o_imem_resp  = (r_state == S_BUSY_I) && i_mem_resp;
  assign o_dmem_resp  = (r_state == S_BUSY_D) && i_mem_resp;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rmask  = r_mem_rmask;
  assign o_mem_wmask  = r_mem_wmask;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter, rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_imem_addr;
  logic [3:0]  i_imem_rmask;
  logic [31:0] o_imem_rdata;
  logic        o_imem_resp;
  logic [31:0] i_dmem_addr;
  logic [3:0]  i_dmem_rmask;
  logic [3:0]  i_dmem_wmask;
  logic [31:0] i_dmem_wdata;
  logic [31:0] o_dmem_rdata;
  logic        o_dmem_resp;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_rmask;
  logic [3:0]  o_mem_wmask;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_resp;
  logic [1:0]  o_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_imem_addr  (i_imem_addr),
    .i_imem_rmask (i_imem_rmask),
    .o_imem_rdata (o_imem_rdata),
    .o_imem_resp  (o_imem_resp),
    .i_dmem_addr  (i_dmem_addr),
    .i_dmem_rmask (i_dmem_rmask),
    .i_dmem_wmask (i_dmem_wmask),
    .i_dmem_wdata (i_dmem_wdata),
    .o_dmem_rdata (o_dmem_rdata),
    .o_dmem_resp  (o_dmem_resp),
    .o_mem_addr   (o_mem_addr),
    .o_mem_rmask  (o_mem_rmask),
    .o_mem_wmask  (o_mem_wmask),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_resp   (i_mem_resp),
    .o_err        (o_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; request and response pulses last one cycle only.
  task automatic cyc();
    @(posedge clk);
    #1;
    i_imem_rmask = '0;
    i_dmem_rmask = '0;
    i_dmem_wmask = '0;
    i_mem_resp   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst          = 1'b1;
    i_imem_addr  = '0;
    i_imem_rmask = '0;
    i_dmem_addr  = '0;
    i_dmem_rmask = '0;
    i_dmem_wmask = '0;
    i_dmem_wdata = '0;
    i_mem_rdata  = '0;
    i_mem_resp   = 1'b0;

    // Reset state
    do_reset();
    #1;
    check("rst_addr",  o_mem_addr, 32'h0);
    check("rst_rmask", {28'h0, o_mem_rmask}, 32'h0);
    check("rst_wmask", {28'h0, o_mem_wmask}, 32'h0);
    check("rst_wdata", o_mem_wdata, 32'h0);
    check("rst_err",   {30'h0, o_err}, 32'h0);

    // Fetch alone, latency 3
    cyc(); i_imem_addr = 32'h0000_0060; i_imem_rmask = 4'hF;           // t
    cyc(); #1;                                                           // t+1
    check("f_rmask_t1", {28'h0, o_mem_rmask}, 32'hF);
    check("f_addr_t1",  o_mem_addr, 32'h60);
    cyc(); #1;                                                           // t+2
    check("f_rmask_t2", {28'h0, o_mem_rmask}, 32'h0);
    check("f_noresp_t2", {31'h0, o_imem_resp}, 32'h0);
    cyc();                                                               // t+3
    cyc(); i_mem_resp = 1'b1; i_mem_rdata = 32'h1234_5678; #1;           // t+4
    check("f_iresp",  {31'h0, o_imem_resp}, 32'h1);
    check("f_irdata", o_imem_rdata, 32'h1234_5678);
    check("f_dresp",  {31'h0, o_dmem_resp}, 32'h0);
    cyc(); #1;
    check("f_iresp_end", {31'h0, o_imem_resp}, 32'h0);

    // Simultaneous fetch and load: data wins
    cyc();
    i_imem_addr = 32'h100; i_imem_rmask = 4'hF;
    i_dmem_addr = 32'h200; i_dmem_rmask = 4'hF;                          // t
    cyc(); #1;                                                           // t+1
    check("both_addr1",  o_mem_addr, 32'h200);
    check("both_rmask1", {28'h0, o_mem_rmask}, 32'hF);
    cyc(); i_mem_resp = 1'b1; #1;                                        // t+2
    check("both_addr_hold", o_mem_addr, 32'h200);
    check("both_dresp", {31'h0, o_dmem_resp}, 32'h1);
    check("both_iresp_no", {31'h0, o_imem_resp}, 32'h0);
    cyc(); #1;                                                           // t+3
    check("both_addr2",  o_mem_addr, 32'h100);
    check("both_rmask2", {28'h0, o_mem_rmask}, 32'hF);
    cyc(); i_mem_resp = 1'b1; #1;                                        // t+4
    check("both_iresp", {31'h0, o_imem_resp}, 32'h1);
    check("both_err", {30'h0, o_err}, 32'h0);

    // Store with partial mask
    cyc();
    i_dmem_addr = 32'h80; i_dmem_wmask = 4'h3; i_dmem_wdata = 32'hDEAD_BEEF;
    cyc(); #1;                                                           // t+1
    check("st_wmask1", {28'h0, o_mem_wmask}, 32'h3);
    check("st_rmask1", {28'h0, o_mem_rmask}, 32'h0);
    check("st_wdata1", o_mem_wdata, 32'hDEAD_BEEF);
    cyc(); #1;                                                           // t+2
    check("st_wmask2", {28'h0, o_mem_wmask}, 32'h0);
    check("st_addr2",  o_mem_addr, 32'h80);
    cyc(); i_mem_resp = 1'b1; #1;                                        // t+3
    check("st_wdata3", o_mem_wdata, 32'hDEAD_BEEF);
    check("st_addr3",  o_mem_addr, 32'h80);
    check("st_dresp",  {31'h0, o_dmem_resp}, 32'h1);

    // Back-to-back fetch: new pulse in the response cycle
    cyc(); i_imem_addr = 32'h10; i_imem_rmask = 4'hF;                    // t
    cyc();                                                               // t+1
    cyc(); i_mem_resp = 1'b1; i_imem_addr = 32'h14; i_imem_rmask = 4'hF; #1;
    check("b2b_iresp1", {31'h0, o_imem_resp}, 32'h1);
    cyc(); #1;                                                           // t+3
    check("b2b_addr",  o_mem_addr, 32'h14);
    check("b2b_rmask", {28'h0, o_mem_rmask}, 32'hF);
    check("b2b_err",   {30'h0, o_err}, 32'h0);
    cyc(); i_mem_resp = 1'b1; #1;                                        // t+4
    check("b2b_iresp2", {31'h0, o_imem_resp}, 32'h1);

    // Overlapping fetch while in service is dropped
    cyc(); i_imem_addr = 32'h40; i_imem_rmask = 4'hF;                    // t
    cyc();                                                               // t+1
    cyc(); i_imem_addr = 32'h44; i_imem_rmask = 4'hF;                    // t+2
    cyc(); i_mem_resp = 1'b1; #1;                                        // t+3
    check("ovl_err",   {30'h0, o_err}, 32'h1);
    check("ovl_iresp", {31'h0, o_imem_resp}, 32'h1);
    cyc(); #1;                                                           // t+4
    check("ovl_nogrant", {28'h0, o_mem_rmask}, 32'h0);
    cyc(); i_mem_resp = 1'b1; #1;                                        // t+5
    check("ovl_iresp_once", {31'h0, o_imem_resp}, 32'h0);

    // Watchdog, then reset mid-transaction
    do_reset();
    #1;
    check("wd_err_clr", {30'h0, o_err}, 32'h0);
    cyc(); i_imem_addr = 32'h300; i_imem_rmask = 4'hF;                   // t
    for (int k = 1; k <= 8; k++) cyc();                                  // t+8
    #1;
    check("wd_err_t8", {30'h0, o_err}, 32'h0);
    cyc(); #1;                                                           // t+9
    check("wd_err_t9", {30'h0, o_err}, 32'h2);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    check("wdr_err",   {30'h0, o_err}, 32'h0);
    check("wdr_addr",  o_mem_addr, 32'h0);
    check("wdr_rmask", {28'h0, o_mem_rmask}, 32'h0);
    check("wdr_wdata", o_mem_wdata, 32'h0);
    cyc(); i_mem_resp = 1'b1; #1;
    check("late_iresp", {31'h0, o_imem_resp}, 32'h0);
    check("late_dresp", {31'h0, o_dmem_resp}, 32'h0);
    cyc(); #1;
    check("late_rmask", {28'h0, o_mem_rmask}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter between the pipelined RV32I core and a single unified backing memory. It captures single-cycle instruction-fetch and data requests, grants one at a time onto the memory port and routes the response back to the owner. It sits outside `cpu`, between its `imem_*`/`dmem_*` ports and the memory model. Data requests have priority by default; a compile-time option switches to round-robin.

## Interface
Parameters:
- `TIMEOUT`, default 1023: cycles in a BUSY state without `mem_resp` before `err[1]` sets; 0 disables the watchdog.

Ports (all synchronous to `clk`):
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  in  32  fetch address, sampled when `imem_rmask != 0`.
- `imem_rmask`  in  4  nonzero for one cycle = fetch request.
- `imem_rdata`  out  32  equals `mem_rdata` (ungated).
- `imem_resp`  out  1  fetch complete.
- `dmem_addr`  in  32  data address.
- `dmem_rmask`  in  4  load byte mask.
- `dmem_wmask`  in  4  store byte mask; request = `(dmem_rmask|dmem_wmask) != 0` for one cycle.
- `dmem_wdata`  in  32  store data.
- `dmem_rdata`  out  32  equals `mem_rdata` (ungated).
- `dmem_resp`  out  1  data access complete.
- `mem_addr`  out  32  granted address, registered and held until the response.
- `mem_rmask`  out  4  registered; nonzero exactly one cycle per grant.
- `mem_wmask`  out  4  registered; nonzero exactly one cycle per grant.
- `mem_wdata`  out  32  registered and held until the response.
- `mem_rdata`  in  32  memory read data.
- `mem_resp`  in  1  memory completion, one cycle.
- `err`  out  2  sticky flags: [0] request overlap, [1] timeout.

## Operation
- **Capture buffers.** There is one pending slot per port: `ipend` holds addr and rmask; `dpend` holds addr, rmask, wmask and wdata.
  - A request pulse loads the slot when the slot is empty and not in service.
  - A request while the same port's slot is full or in service is dropped and sets `err[0]`.
- **FSM states.** The FSM has states IDLE, BUSY_I and BUSY_D.
- **IDLE.**
  - If any slot is full, grant one per the priority rule.
  - On grant, drive `mem_addr`/`mem_wdata` and the masks from the slot, clear the slot's pending bit, and go to BUSY_I or BUSY_D.
  - With no slot full, stay in IDLE with masks 0.
- **BUSY_x.**
  - Masks return to 0 after the grant cycle; addr and wdata hold.
  - On `mem_resp`, assert `imem_resp` (BUSY_I) or `dmem_resp` (BUSY_D) combinationally in the same cycle, then go to IDLE.
- **Priority (default).** Fixed: `dpend` wins over `ipend`.
- **Spurious responses.** `mem_resp` in IDLE is ignored: no resp output and no state change.
- **Simultaneous events.**
  - A request pulse that arrives in the same cycle its own port's `mem_resp` fires is legal and is captured.
  - Requests on both ports in the same cycle are both captured.
- **Watchdog.** A counter clears on entry to BUSY and increments each BUSY cycle. Reaching `TIMEOUT` sets `err[1]`; the FSM keeps waiting.
- **Transparency.** Addresses and masks pass unmodified; no alignment or byte steering.
- **Reset.** `rst` at any time, including mid-transaction:
  - state becomes IDLE, both slots empty, counter 0;
  - `mem_addr`, `mem_wdata`, masks, `err` and resp outputs become 0;
  - a `mem_resp` for the aborted access arriving after reset is ignored.

## Timing
- Request pulse at cycle t, slot empty, FSM IDLE: `mem_*mask` is nonzero at cycle t+1.
- `mem_resp` at cycle r: the requester's resp is at cycle r (0 added cycles). The FSM is IDLE at r+1, and the next grant is at r+1 if a slot is full.
- Minimum spacing between grants is 2 cycles (grant, then resp at the earliest one cycle later).
- Worst-case fetch wait under fixed priority is unbounded while data requests keep arriving; the round-robin build bounds it to one data transaction.

## Configuration
- **`MEM_ARB_ROUND_ROBIN_EN` defined:** a `last_grant` flop (reset 0 = I) tracks the most recent grant. When both slots are full, the port not granted last wins.
- **`MEM_ARB_ROUND_ROBIN_EN` undefined:** fixed data priority as above; no `last_grant` flop.

## Test plan
- Fetch 0x0000_0060 alone, memory latency 3: `mem_rmask`=0xF at t+1 only, and `imem_resp` plus `imem_rdata` equal to the memory word at t+4. `dmem_resp` is never asserted.
- Fetch 0x100 and load 0x200 in the same cycle:
  - fixed build: `mem_addr`=0x200 first; after its resp, 0x100 is granted the next cycle;
  - round-robin build after reset: 0x100 first.
- Store 0x80, wmask 0x3, wdata 0xDEAD_BEEF: `mem_wmask`=0x3 for one cycle, and `mem_addr`/`mem_wdata` hold until `mem_resp`, coinciding with `dmem_resp`.
- Second fetch pulse while the first is in service: dropped, `err`=2'b01, exactly one `imem_resp` delivered.
- `TIMEOUT`=8 with memory never responding: `err[1]`=1 after 8 BUSY cycles. Then `rst`: all outputs 0. A late `mem_resp` produces no resp output.
- Back-to-back: new fetch pulse in the same cycle as the previous `mem_resp`: captured and granted the next cycle, no `err`.
